// File: rtl/decode_regfile.sv
// decode_regfile: decode-side register file with pending-write scoreboard.
// Receives writebacks (wb_reg_*), serves two combinational read ports
// (rs1/rs2) and flags read-after-write hazards against outstanding writes.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   wb_reg_en/id/data         writeback register write
//   rs1_id/rs2_id, rs*_used   read indices and use flags of decoded instr
//   rs1_data/rs2_data         read data
//   issue_en/issue_rd         instruction leaving decode marks rd busy
//   raw_hazard                decode must stall
//   busy_mask                 scoreboard, bit i = write to reg i pending
// Macro REGFILE_BYPASS_EN: forwards same-cycle writeback data to the read
// ports and releases the hazard in the writeback cycle.
module decode_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_reg_en,
    input  logic [ADDR_W-1:0]    wb_reg_id,
    input  logic [DATA_W-1:0]    wb_reg_data,
    input  logic [ADDR_W-1:0]    rs1_id,
    input  logic [ADDR_W-1:0]    rs2_id,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    output logic [DATA_W-1:0]    rs1_data,
    output logic [DATA_W-1:0]    rs2_data,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 raw_hazard,
    output logic [2**ADDR_W-1:0] busy_mask
);
    localparam int N = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [N];
    logic [N-1:0]      busy_q, busy_d, busy_eff, clr_mask, set_mask;
    logic [DATA_W-1:0] rd1, rd2;
    logic              wb_wr;

    assign wb_wr    = wb_reg_en && (wb_reg_id != '0);
    assign clr_mask = wb_wr ? (N'(1) << wb_reg_id) : '0;
    assign set_mask = (issue_en && (issue_rd != '0)) ? (N'(1) << issue_rd) : '0;
    // set applied after clear: a newer issuer owns the register
    assign busy_d   = (busy_q & ~clr_mask) | set_mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wb_wr) regs_q[wb_reg_id] <= wb_reg_data;
            busy_q <= busy_d;
        end
    end

    assign rd1 = (rs1_id == '0) ? '0 : regs_q[rs1_id];
    assign rd2 = (rs2_id == '0) ? '0 : regs_q[rs2_id];

`ifdef REGFILE_BYPASS_EN
    assign busy_eff = busy_q & ~clr_mask;
    assign rs1_data = (wb_wr && wb_reg_id == rs1_id) ? wb_reg_data : rd1;
    assign rs2_data = (wb_wr && wb_reg_id == rs2_id) ? wb_reg_data : rd2;
`else
    assign busy_eff = busy_q;
    assign rs1_data = rd1;
    assign rs2_data = rd2;
`endif

    assign raw_hazard = (rs1_used & busy_eff[rs1_id]) | (rs2_used & busy_eff[rs2_id]);
    assign busy_mask  = busy_q;
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed self-checking bench for decode_regfile.
module tb_decode_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_id;
    logic [31:0] wb_reg_data;
    logic [4:0]  rs1_id, rs2_id;
    logic        rs1_used, rs2_used;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        raw_hazard;
    logic [31:0] busy_mask;

    int errors = 0;
    int checks = 0;

    decode_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_en(wb_reg_en), .wb_reg_id(wb_reg_id), .wb_reg_data(wb_reg_data),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .raw_hazard(raw_hazard), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // issuing a second writer of a busy register is illegal unless the
    // same cycle's writeback retires the first one
    always @(posedge clk)
        if (rst && issue_en && !(wb_reg_en && wb_reg_id == issue_rd))
            assert (!busy_mask[issue_rd]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] id, input logic [31:0] d);
        wb_reg_en = en; wb_reg_id = id; wb_reg_data = d;
    endtask

    task automatic iss(input logic en, input logic [4:0] rd);
        issue_en = en; issue_rd = rd;
    endtask

    initial begin
        rst = 1'b0;
        wb(0, 0, 0); iss(0, 0);
        rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        tick(); tick();
        rst = 1'b1;

        // some writes and a pending issue, then reset discards them
        wb(1, 1, 32'd11); tick();
        wb(1, 2, 32'd22); iss(1, 6); tick();
        wb(0, 0, 0); iss(0, 0);
        rs1_id = 1; rs2_id = 2; #1;
        chk("pre_rst_rs1", rs1_data, 32'd11);
        chk("pre_rst_rs2", rs2_data, 32'd22);
        chk("pre_rst_busy", busy_mask, 32'h40);
        rst = 1'b0; tick(); tick(); rst = 1'b1; #1;
        chk("rst_rs1", rs1_data, 32'd0);
        chk("rst_rs2", rs2_data, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        rs1_id = 6; rs1_used = 1; #1;
        chk("rst_hazard", {31'd0, raw_hazard}, 32'd0);
        rs1_used = 0;

        // x0 protection
        rs1_id = 0;
        wb(1, 0, 32'hDEADBEEF); #1;
        chk("x0_same_cycle", rs1_data, 32'd0);
        tick();
        wb(0, 0, 0); iss(1, 0); tick();
        iss(0, 0); #1;
        chk("x0_read", rs1_data, 32'd0);
        chk("x0_busy", busy_mask, 32'd0);

        // write then read
        wb(1, 5, 32'h12345678); tick();
        wb(0, 0, 0);
        rs1_id = 5; rs2_id = 6; #1;
        chk("wr_rd_rs1", rs1_data, 32'h12345678);
        chk("wr_rd_rs2", rs2_data, 32'd0);

        // same-cycle write-through
        rs2_id = 7;
        wb(1, 7, 32'hA5A5A5A5); #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same", rs2_data, 32'hA5A5A5A5);
`else
        chk("bypass_same", rs2_data, 32'd0);
`endif
        tick();
        wb(0, 0, 0); #1;
        chk("bypass_next", rs2_data, 32'hA5A5A5A5);

        // hazard lifecycle on rs1
        iss(1, 3); tick();
        iss(0, 0); #1;
        chk("haz_busy_set", busy_mask, 32'h8);
        rs1_id = 3; rs1_used = 1; #1;
        chk("haz_used", {31'd0, raw_hazard}, 32'd1);
        rs1_used = 0; #1;
        chk("haz_unused", {31'd0, raw_hazard}, 32'd0);
        rs1_used = 1;
        wb(1, 3, 32'd33); #1;
`ifdef REGFILE_BYPASS_EN
        chk("haz_wb_cycle", {31'd0, raw_hazard}, 32'd0);
        chk("haz_wb_data", rs1_data, 32'd33);
`else
        chk("haz_wb_cycle", {31'd0, raw_hazard}, 32'd1);
        chk("haz_wb_data", rs1_data, 32'd0);
`endif
        tick();
        wb(0, 0, 0); #1;
        chk("haz_after_wb", {31'd0, raw_hazard}, 32'd0);
        chk("haz_busy_clr", busy_mask, 32'd0);
        chk("haz_data", rs1_data, 32'd33);
        rs1_used = 0;

        // hazard via rs2
        iss(1, 8); tick();
        iss(0, 0);
        rs2_id = 8; rs2_used = 1; #1;
        chk("haz2_used", {31'd0, raw_hazard}, 32'd1);
        rs2_used = 0; #1;
        chk("haz2_unused", {31'd0, raw_hazard}, 32'd0);
        wb(1, 8, 32'd88); tick();
        wb(0, 0, 0); #1;
        chk("haz2_busy_clr", busy_mask, 32'd0);

        // set/clear collision on the same index: set wins
        iss(1, 4); tick();
        iss(0, 0); #1;
        chk("coll_busy4", busy_mask, 32'h10);
        wb(1, 4, 32'd44); iss(1, 4); tick();
        wb(0, 0, 0); iss(0, 0); #1;
        chk("coll_same", busy_mask, 32'h10);
        wb(1, 4, 32'd45); tick();
        wb(0, 0, 0); #1;
        chk("coll_retire4", busy_mask, 32'd0);

        // clear and set of different indices
        iss(1, 9); tick();
        wb(1, 9, 32'd99); iss(1, 10); tick();
        wb(0, 0, 0); iss(0, 0); #1;
        chk("coll_diff", busy_mask, 32'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
